command_credit_arbiter: RTL and testbench

- Shares the single PSL command interface among NUM_REQ command requesters (read, write, wed, restart, prefetch engines).
- Gates every issue on PSL command credits and tracks outstanding commands.
- Recovers credits from the response path, i.e. the response control output valid and credits fields.
- Sits between the per-engine command buffers and the command issue register, and is the sequencer for the response-credit loop.

---
 rtl/command_credit_arbiter_pkg.sv | 22 ++
 rtl/command_credit_arbiter_rr_arbiter.sv | 49 ++++
 rtl/command_credit_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_command_credit_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/command_credit_arbiter_pkg.sv
// Shared definitions for the PSL command credit arbiter.
//   arb_state_e    : arbiter FSM state encoding (IDLE, INIT, RUN, DRAIN)
//   ERR_*          : bit positions inside the sticky arb_error vector
//   CREDIT_W_DEF   : default width of the credit / outstanding counters
//   RSP_CREDIT_W   : width of the signed credit delta carried by responses
package command_credit_arbiter_pkg;

   localparam int CREDIT_W_DEF = 8;
   localparam int RSP_CREDIT_W = 9;

   localparam int ERR_CREDIT_OVF = 0;
   localparam int ERR_OUT_UNF    = 1;
   localparam int ERR_RSP_IDLE   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

endpackage

// File: rtl/command_credit_arbiter_rr_arbiter.sv
// Request arbiter for the command credit arbiter.
// Ports:
//   req       : request vector (already qualified by credits/state)
//   ptr       : round-robin start index (absent under CMD_ARB_FIXED_PRIORITY_EN)
//   grant     : one-hot grant
//   grant_idx : index of the granted requester
//   grant_vld : any grant this cycle
// Build option: CMD_ARB_FIXED_PRIORITY_EN turns this into a plain
// lowest-index-wins priority encoder.
module command_credit_arbiter_rr_arbiter
   import command_credit_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
`ifndef CMD_ARB_FIXED_PRIORITY_EN
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_vld
);

   localparam int IDX_W = $clog2(NUM_REQ);

   always_comb begin
      int k;
      k         = 0;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      // Scan in reverse search order so the last hit is the winner.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef CMD_ARB_FIXED_PRIORITY_EN
         k = i;
`else
         k = int'(ptr) + i;
         if (k >= NUM_REQ) k = k - NUM_REQ;
`endif
         if (req[k]) begin
            grant     = '0;
            grant[k]  = 1'b1;
            grant_idx = IDX_W'(k);
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/command_credit_arbiter.sv
// Shares the PSL command interface among NUM_REQ command engines, gating
// every issue on PSL command credits and recovering credits from responses.
// Ports:
//   clock, rstn                 : clock, asynchronous active-low reset
//   enabled_in                  : AFU enable (registered before use)
//   credit_init_valid/_init     : one-cycle pulse loading the initial credits
//   req_valid/req_payload       : per-requester commands, slice i = requester i
//   req_ready                   : one-hot combinational accept
//   rsp_valid/rsp_credits       : response strobe and signed credit delta
//   cmd_out_valid/_payload/_src : registered issued command (1 cycle latency)
//   credits_available           : current credit count
//   outstanding                 : issued but not yet responded commands
//   arb_error                   : sticky [0] credit ovf, [1] outstanding unf,
//                                 [2] response while IDLE/INIT
// Build option: CMD_ARB_FIXED_PRIORITY_EN selects fixed priority (lowest
// index wins) instead of round robin.
module command_credit_arbiter
   import command_credit_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int CMD_W    = 64,
   parameter int CREDIT_W = CREDIT_W_DEF
) (
   input  logic                       clock,
   input  logic                       rstn,
   input  logic                       enabled_in,
   input  logic                       credit_init_valid,
   input  logic [CREDIT_W-1:0]        credit_init,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*CMD_W-1:0]   req_payload,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       rsp_valid,
   input  logic [RSP_CREDIT_W-1:0]    rsp_credits,
   output logic                       cmd_out_valid,
   output logic [CMD_W-1:0]           cmd_out_payload,
   output logic [$clog2(NUM_REQ)-1:0] cmd_out_src,
   output logic [CREDIT_W-1:0]        credits_available,
   output logic [CREDIT_W-1:0]        outstanding,
   output logic [2:0]                 arb_error
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SUM_W = CREDIT_W + 2;

   // Returns {out_of_range, clamped credit count}.
   function automatic logic [CREDIT_W:0] credit_sat(input logic signed [SUM_W-1:0] sum,
                                                    input logic [CREDIT_W-1:0] cmax);
      if (sum < 0) return {1'b1, {CREDIT_W{1'b0}}};
      if (sum > $signed({2'b00, cmax})) return {1'b1, cmax};
      return {1'b0, sum[CREDIT_W-1:0]};
   endfunction

   // Returns {underflow, next outstanding}; saturates high without blocking.
   function automatic logic [CREDIT_W:0] outstanding_step(input logic [CREDIT_W-1:0] cur,
                                                          input logic inc,
                                                          input logic dec);
      case ({inc, dec})
         2'b10:   return {1'b0, (&cur) ? cur : cur + 1'b1};
         2'b01:   return (cur == '0) ? {1'b1, cur} : {1'b0, cur - 1'b1};
         default: return {1'b0, cur};
      endcase
   endfunction

   arb_state_e          state_q, state_d;
   logic                en_q, en_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic [CREDIT_W-1:0] credit_max_q, credit_max_d;
   logic [CREDIT_W-1:0] outstanding_q, outstanding_d;
   logic [2:0]          err_q, err_d;
   logic                cmd_vld_q, cmd_vld_d;
   logic [CMD_W-1:0]    cmd_payload_q, cmd_payload_d;
   logic [IDX_W-1:0]    cmd_src_q, cmd_src_d;
`ifndef CMD_ARB_FIXED_PRIORITY_EN
   logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

   logic                        arb_en;
   logic [NUM_REQ-1:0]          grant;
   logic [IDX_W-1:0]            gidx;
   logic                        gvld;
   logic                        counting;
   logic signed [RSP_CREDIT_W-1:0] rsp_signed;
   logic signed [SUM_W-1:0]     rsp_delta;
   logic signed [SUM_W-1:0]     credit_sum;
   logic [CREDIT_W:0]           credit_res;
   logic [CREDIT_W:0]           out_res;

   assign arb_en     = (state_q == ST_RUN) && (credits_q != '0);
   assign counting   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign rsp_signed = rsp_credits;

   command_credit_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid & {NUM_REQ{arb_en}}),
`ifndef CMD_ARB_FIXED_PRIORITY_EN
      .ptr       (ptr_q),
`endif
      .grant     (grant),
      .grant_idx (gidx),
      .grant_vld (gvld)
   );

   assign req_ready = grant;

   always_comb begin
      state_d       = state_q;
      en_d          = enabled_in;
      credits_d     = credits_q;
      credit_max_d  = credit_max_q;
      outstanding_d = outstanding_q;
      err_d         = err_q;
      cmd_vld_d     = gvld;
      cmd_payload_d = cmd_payload_q;
      cmd_src_d     = cmd_src_q;
`ifndef CMD_ARB_FIXED_PRIORITY_EN
      ptr_d         = ptr_q;
`endif

      if (gvld) begin
         cmd_payload_d = req_payload[int'(gidx)*CMD_W +: CMD_W];
         cmd_src_d     = gidx;
`ifndef CMD_ARB_FIXED_PRIORITY_EN
         ptr_d         = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
`endif
      end

      // Grant and response deltas combine before clamping.
      rsp_delta  = (rsp_valid && counting) ? SUM_W'(rsp_signed) : '0;
      credit_sum = $signed({2'b00, credits_q}) - $signed({{(SUM_W-1){1'b0}}, gvld}) + rsp_delta;
      credit_res = credit_sat(credit_sum, credit_max_q);
      out_res    = outstanding_step(outstanding_q, gvld, rsp_valid);

      case (state_q)
         ST_IDLE: begin
            if (en_q) begin
               state_d = ST_INIT;
               err_d   = '0;
            end
         end
         ST_INIT: begin
            if (!en_q) begin
               state_d = ST_IDLE;
            end else if (credit_init_valid && (credit_init != '0)) begin
               credits_d    = credit_init;
               credit_max_d = credit_init;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en_q) state_d = ST_DRAIN;
         end
         default: begin
            if (en_q) state_d = ST_RUN;
            else if ((outstanding_q == '0) && !rsp_valid) state_d = ST_IDLE;
         end
      endcase

      if (counting) begin
         credits_d             = credit_res[CREDIT_W-1:0];
         outstanding_d         = out_res[CREDIT_W-1:0];
         err_d[ERR_CREDIT_OVF] = err_q[ERR_CREDIT_OVF] | credit_res[CREDIT_W];
         err_d[ERR_OUT_UNF]    = err_q[ERR_OUT_UNF] | out_res[CREDIT_W];
      end else if (rsp_valid) begin
         err_d[ERR_RSP_IDLE] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         en_q          <= 1'b0;
         credits_q     <= '0;
         credit_max_q  <= '0;
         outstanding_q <= '0;
         err_q         <= '0;
         cmd_vld_q     <= 1'b0;
         cmd_payload_q <= '0;
         cmd_src_q     <= '0;
`ifndef CMD_ARB_FIXED_PRIORITY_EN
         ptr_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         credits_q     <= credits_d;
         credit_max_q  <= credit_max_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         cmd_vld_q     <= cmd_vld_d;
         cmd_payload_q <= cmd_payload_d;
         cmd_src_q     <= cmd_src_d;
`ifndef CMD_ARB_FIXED_PRIORITY_EN
         ptr_q         <= ptr_d;
`endif
      end
   end

   assign cmd_out_valid     = cmd_vld_q;
   assign cmd_out_payload   = cmd_payload_q;
   assign cmd_out_src       = cmd_src_q;
   assign credits_available = credits_q;
   assign outstanding       = outstanding_q;
   assign arb_error         = err_q;

endmodule

// File: tb/tb_command_credit_arbiter.sv
// Directed bench for command_credit_arbiter (NUM_REQ=4, CMD_W=64, CREDIT_W=8).
// Inputs change 1 time unit after the rising edge; outputs are checked
// there too, i.e. well away from the active edge.
module tb_command_credit_arbiter;

   logic         clock = 1'b0;
   logic         rstn;
   logic         enabled_in;
   logic         credit_init_valid;
   logic [7:0]   credit_init;
   logic [3:0]   req_valid;
   logic [255:0] req_payload;
   logic [3:0]   req_ready;
   logic         rsp_valid;
   logic [8:0]   rsp_credits;
   logic         cmd_out_valid;
   logic [63:0]  cmd_out_payload;
   logic [1:0]   cmd_out_src;
   logic [7:0]   credits_available;
   logic [7:0]   outstanding;
   logic [2:0]   arb_error;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   command_credit_arbiter #(.NUM_REQ(4), .CMD_W(64), .CREDIT_W(8)) dut (
      .clock             (clock),
      .rstn              (rstn),
      .enabled_in        (enabled_in),
      .credit_init_valid (credit_init_valid),
      .credit_init       (credit_init),
      .req_valid         (req_valid),
      .req_payload       (req_payload),
      .req_ready         (req_ready),
      .rsp_valid         (rsp_valid),
      .rsp_credits       (rsp_credits),
      .cmd_out_valid     (cmd_out_valid),
      .cmd_out_payload   (cmd_out_payload),
      .cmd_out_src       (cmd_out_src),
      .credits_available (credits_available),
      .outstanding       (outstanding),
      .arb_error         (arb_error)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rsp(input logic [8:0] delta);
      rsp_valid   = 1'b1;
      rsp_credits = delta;
      tick();
      rsp_valid   = 1'b0;
      rsp_credits = '0;
   endtask

   function automatic logic [63:0] pay(input int i);
      return 64'hCAFE_0000_0000_0000 + 64'(i);
   endfunction

   initial begin
      logic [1:0] exp_src;
      rstn = 1'b0; enabled_in = 1'b0; credit_init_valid = 1'b0; credit_init = '0;
      req_valid = '0; rsp_valid = 1'b0; rsp_credits = '0;
      for (int i = 0; i < 4; i++) req_payload[i*64 +: 64] = pay(i);
      tick(); tick();

      // Reset state
      check("rst_cmd_valid", 64'(cmd_out_valid), 64'd0);
      check("rst_credits", 64'(credits_available), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err", 64'(arb_error), 64'd0);
      req_valid = 4'b1111; #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      rstn = 1'b1;
      tick();

      // Bring-up with 4 credits, all requesters valid for 8 cycles
      enabled_in = 1'b1;
      tick(); tick();
      credit_init_valid = 1'b1; credit_init = 8'd4;
      tick();
      credit_init_valid = 1'b0;
      check("init_credits", 64'(credits_available), 64'd4);
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("rr_ready", 64'(req_ready), (i < 4) ? 64'(1 << i) : 64'd0);
         tick();
         check("rr_out_valid", 64'(cmd_out_valid), (i < 4) ? 64'd1 : 64'd0);
         if (i < 4) begin
            check("rr_out_src", 64'(cmd_out_src), 64'(i));
            check("rr_out_payload", cmd_out_payload, pay(i));
         end
      end
      check("rr_credits0", 64'(credits_available), 64'd0);
      check("rr_outstanding4", 64'(outstanding), 64'd4);

      // Credit return unblocks requester 2
      req_valid = 4'b0100; #1;
      check("nocredit_ready", 64'(req_ready), 64'd0);
      rsp(9'd1);
      check("ret_credits", 64'(credits_available), 64'd1);
      check("ret_outstanding", 64'(outstanding), 64'd3);
      check("ret_ready", 64'(req_ready), 64'b0100);
      tick();
      req_valid = '0;
      check("ret_src", 64'(cmd_out_src), 64'd2);
      check("ret_credits_after", 64'(credits_available), 64'd0);
      check("ret_outstanding_after", 64'(outstanding), 64'd4);

      // Same-cycle grant and response
      rsp(9'd2);
      check("pre_same_credits", 64'(credits_available), 64'd2);
      check("pre_same_outstanding", 64'(outstanding), 64'd3);
      req_valid = 4'b0100; #1;
      check("same_ready", 64'(req_ready), 64'b0100);
      rsp(9'd1);
      req_valid = '0;
      check("same_cmd_valid", 64'(cmd_out_valid), 64'd1);
      check("same_credits", 64'(credits_available), 64'd2);
      check("same_outstanding", 64'(outstanding), 64'd3);

      // Drain with two outstanding commands
      rsp(9'd0);
      check("pre_drain_outstanding", 64'(outstanding), 64'd2);
      enabled_in = 1'b0;
      tick(); tick();
      req_valid = 4'b1111; #1;
      check("drain_ready", 64'(req_ready), 64'd0);
      rsp(9'd1);
      check("drain_outstanding1", 64'(outstanding), 64'd1);
      check("drain_credits3", 64'(credits_available), 64'd3);
      rsp(9'd0);
      check("drain_outstanding0", 64'(outstanding), 64'd0);
      tick();
      check("drain_err_clean", 64'(arb_error), 64'd0);
      rsp(9'd5);
      check("idle_rsp_err", 64'(arb_error), 64'b100);
      check("idle_rsp_credits", 64'(credits_available), 64'd3);
      check("idle_ready", 64'(req_ready), 64'd0);
      req_valid = '0;

      // Re-init: zero credit_init is ignored, errors clear on IDLE->INIT
      enabled_in = 1'b1;
      tick(); tick();
      check("reinit_err_clear", 64'(arb_error), 64'd0);
      credit_init_valid = 1'b1; credit_init = 8'd0;
      tick();
      check("zero_init_credits", 64'(credits_available), 64'd3);
      credit_init = 8'd4;
      tick();
      credit_init_valid = 1'b0;
      check("reinit_credits", 64'(credits_available), 64'd4);

      // Overflow saturation, outstanding underflow, negative clamp
      rsp(9'd3);
      check("ovf_credits", 64'(credits_available), 64'd4);
      check("ovf_err", 64'(arb_error), 64'b011);
      rsp(9'd0);
      check("unf_outstanding", 64'(outstanding), 64'd0);
      check("unf_err", 64'(arb_error), 64'b011);
      rsp(9'h1F8);
      check("neg_clamp_credits", 64'(credits_available), 64'd0);

      // Reset in the middle of an issued command
      rsp(9'd2);
      req_valid = 4'b0001;
      tick();
      check("midrst_pre_valid", 64'(cmd_out_valid), 64'd1);
      rstn = 1'b0; enabled_in = 1'b0; req_valid = '0;
      #1;
      check("midrst_valid", 64'(cmd_out_valid), 64'd0);
      check("midrst_credits", 64'(credits_available), 64'd0);
      check("midrst_err", 64'(arb_error), 64'd0);
      tick();
      rstn = 1'b1;
      tick();

      // Two contending requesters with 8 credits
      enabled_in = 1'b1;
      tick(); tick();
      credit_init_valid = 1'b1; credit_init = 8'd8;
      tick();
      credit_init_valid = 1'b0;
      req_valid = 4'b1001;
      for (int i = 0; i < 8; i++) begin
`ifdef CMD_ARB_FIXED_PRIORITY_EN
         exp_src = 2'd0;
`else
         exp_src = (i % 2 == 1) ? 2'd3 : 2'd0;
`endif
         #1;
         check("pair_ready", 64'(req_ready), 64'(1 << exp_src));
         tick();
         check("pair_src", 64'(cmd_out_src), 64'(exp_src));
      end
      check("pair_credits", 64'(credits_available), 64'd0);
      check("pair_outstanding", 64'(outstanding), 64'd8);
      req_valid = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
